// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port SRAM between two requesters.
// Zero-fills the memory after reset and returns fixed two-cycle responses.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_INIT  | walking the fill counter, one zero write per cycle
// ST_SERVE | arbitrating requests onto the memory port
module sram_bank_arbiter #(
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 16,
    parameter int MEM_WORDS     = 6144,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic                  mem_CEB,
    output logic                  mem_WEB,
    output logic [DATA_WIDTH-1:0] mem_D,
    input  logic [DATA_WIDTH-1:0] mem_Q,
    output logic                  init_done
);

    typedef enum logic {ST_INIT, ST_SERVE} state_t;

    localparam logic [ADDR_WIDTH-1:0] INIT_LAST   = ADDR_WIDTH'(MEM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_WORDS_W = (ADDR_WIDTH + 1)'(MEM_WORDS);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic                    last_grant;
    logic                    serving;
    logic                    grant0, grant1, gnt_any;
    logic                    gnt_write, gnt_err;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic [DATA_WIDTH-1:0]   gnt_wdata;
    logic                    ceb_c, web_c;
    logic                    tag_valid, tag_port, tag_write, tag_err;
    logic                    rd_ok;

    assign serving   = (state == ST_SERVE);
    assign init_done = serving;

    // Both valid: the port that did not win last time gets the grant.
    assign grant0  = serving && p0_valid && (!p1_valid || last_grant);
    assign grant1  = serving && p1_valid && (!p0_valid || !last_grant);
    assign gnt_any = grant0 || grant1;

    assign gnt_write = grant1 ? p1_write : p0_write;
    assign gnt_addr  = grant1 ? p1_addr  : p0_addr;
    assign gnt_wdata = grant1 ? p1_wdata : p0_wdata;
    assign gnt_err   = ({1'b0, gnt_addr} >= MEM_WORDS_W);

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= INIT_ON_RESET ? ST_INIT : ST_SERVE;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ceb_c     = 1'b1;
        web_c     = 1'b1;
        mem_A     = '0;
        mem_D     = '0;
        case (state)
            ST_INIT: begin
                ceb_c = 1'b0;
                web_c = 1'b0;
                mem_A = init_cnt;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (gnt_any && !gnt_err) begin
                    ceb_c = 1'b0;
                    web_c = ~gnt_write;
                    mem_A = gnt_addr;
                    mem_D = gnt_wdata;
                end
            end
            default: state_nxt = ST_SERVE;
        endcase
    end

    // Keep the macro deselected for the whole reset pulse, whatever the state decode says.
    assign mem_CEB = RST | ceb_c;
    assign mem_WEB = RST | web_c;

    assign rd_ok = tag_valid && !tag_write && !tag_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= 1'b1;
            tag_valid  <= 1'b0;
            tag_port   <= 1'b0;
            tag_write  <= 1'b0;
            tag_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            if (gnt_any) begin
                last_grant <= grant1;
            end
            tag_valid  <= gnt_any;
            tag_port   <= grant1;
            tag_write  <= gnt_write;
            tag_err    <= gnt_err;
            rsp0_valid <= tag_valid && !tag_port;
            rsp0_err   <= tag_valid && !tag_port && tag_err;
            rsp0_rdata <= (rd_ok && !tag_port) ? mem_Q : '0;
            rsp1_valid <= tag_valid && tag_port;
            rsp1_err   <= tag_valid && tag_port && tag_err;
            rsp1_rdata <= (rd_ok && tag_port) ? mem_Q : '0;
        end
    end

endmodule
